// File: rtl/usb_cmd_reader.sv
// FX2 slave-FIFO command reader: pulls fixed-size frames from EP2 OUT and offers them
// on a valid/ready port. Define USB_CMD_CHECKSUM_EN for 5-byte frames with an XOR check byte.
module usb_cmd_reader #(
  parameter int RD_PULSE = 2,
  parameter int RECOVER  = 3,
  parameter int TIMEOUT  = 1024
) (
  input  logic        mclk_i,
  input  logic        reset_i,
  input  logic [7:0]  usb_d_i,
  input  logic        usb_flaga_i,
  output logic [1:0]  usb_fifoadr_o,
  output logic        usb_sloe_o,
  output logic        usb_slrd_o,
  output logic        cmd_valid_o,
  input  logic        cmd_ready_i,
  output logic [7:0]  cmd_op_o,
  output logic [23:0] cmd_arg_o,
  output logic        cmd_err_o
);
`ifdef USB_CMD_CHECKSUM_EN
  localparam int NBYTES = 5;
`else
  localparam int NBYTES = 4;
`endif

  typedef enum logic [2:0] {S_IDLE, S_OE_SETUP, S_STROBE, S_RECOVER, S_HOLD} state_t;

  state_t      state_q, state_d;
  logic [7:0]  ph_q, ph_d;
  logic [2:0]  idx_q, idx_d;
  logic [15:0] tmo_q, tmo_d;
  logic [7:0]  op_q, op_d;
  logic [23:0] arg_q, arg_d;
  logic        valid_q, valid_d;
  logic        err_q, err_d;
  logic        done_q, done_d;
  logic        flag_s1_q, flag_s2_q;
  logic        sloe_q, slrd_q;
  logic        capture;

  always_comb begin
    state_d = state_q;
    ph_d    = ph_q;
    idx_d   = idx_q;
    tmo_d   = tmo_q;
    op_d    = op_q;
    arg_d   = arg_q;
    valid_d = valid_q;
    err_d   = 1'b0;
    done_d  = done_q;
    capture = 1'b0;
    case (state_q)
      S_IDLE:     if (flag_s2_q && !valid_q) state_d = S_OE_SETUP;
      S_OE_SETUP: begin
        state_d = S_STROBE;
        ph_d    = '0;
      end
      S_STROBE: begin
        if (ph_q == 8'(RD_PULSE - 1)) begin
          capture = 1'b1;
          state_d = S_RECOVER;
          ph_d    = '0;
        end else begin
          ph_d = ph_q + 8'd1;
        end
      end
      S_RECOVER: begin
        // Chain straight into the next read so a full FIFO streams at one byte per pass.
        if (ph_q == 8'(RECOVER - 1)) begin
          if (done_q) begin
            state_d = S_HOLD;
            valid_d = 1'b1;
            done_d  = 1'b0;
          end else if (flag_s2_q && !valid_q) begin
            state_d = S_OE_SETUP;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          ph_d = ph_q + 8'd1;
        end
      end
      S_HOLD: begin
        if (valid_q && cmd_ready_i) begin
          state_d = S_IDLE;
          valid_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A capture always beats the inter-byte timeout.
    if (capture) begin
      tmo_d = '0;
      case (idx_q)
        3'd0:    op_d          = usb_d_i;
        3'd1:    arg_d[23:16]  = usb_d_i;
        3'd2:    arg_d[15:8]   = usb_d_i;
        3'd3:    arg_d[7:0]    = usb_d_i;
        default: ;
      endcase
      if (idx_q == 3'(NBYTES - 1)) begin
        idx_d = '0;
`ifdef USB_CMD_CHECKSUM_EN
        done_d = (usb_d_i == (op_q ^ arg_q[23:16] ^ arg_q[15:8] ^ arg_q[7:0]));
        err_d  = (usb_d_i != (op_q ^ arg_q[23:16] ^ arg_q[15:8] ^ arg_q[7:0]));
`else
        done_d = 1'b1;
`endif
      end else begin
        idx_d = idx_q + 3'd1;
      end
    end else if (state_q == S_IDLE && idx_q != 3'd0) begin
      if (tmo_q == 16'(TIMEOUT - 1)) begin
        tmo_d = '0;
        idx_d = '0;
        err_d = 1'b1;
      end else begin
        tmo_d = tmo_q + 16'd1;
      end
    end else if (idx_q == 3'd0) begin
      tmo_d = '0;
    end
  end

  always_ff @(posedge mclk_i) begin
    if (reset_i) begin
      state_q   <= S_IDLE;
      ph_q      <= '0;
      idx_q     <= '0;
      tmo_q     <= '0;
      op_q      <= '0;
      arg_q     <= '0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
      done_q    <= 1'b0;
      flag_s1_q <= 1'b0;
      flag_s2_q <= 1'b0;
      sloe_q    <= 1'b1;
      slrd_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      ph_q      <= ph_d;
      idx_q     <= idx_d;
      tmo_q     <= tmo_d;
      op_q      <= op_d;
      arg_q     <= arg_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
      done_q    <= done_d;
      flag_s1_q <= usb_flaga_i;
      flag_s2_q <= flag_s1_q;
      // Strobes come from flops so the FX2 never sees a decode glitch.
      sloe_q    <= !(state_d == S_OE_SETUP || state_d == S_STROBE || state_d == S_RECOVER);
      slrd_q    <= (state_d != S_STROBE);
    end
  end

  assign usb_fifoadr_o = 2'b00;
  assign usb_sloe_o    = sloe_q;
  assign usb_slrd_o    = slrd_q;
  assign cmd_valid_o   = valid_q;
  assign cmd_op_o      = op_q;
  assign cmd_arg_o     = arg_q;
  assign cmd_err_o     = err_q;

endmodule

// File: tb/tb_usb_cmd_reader.sv
// Bench for usb_cmd_reader: a queue-based FX2 FIFO model feeds bytes, a frame-level model
// predicts commands and errors, and protocol rules are checked every cycle.
module tb_usb_cmd_reader;
  localparam int RD_PULSE = 2;
  localparam int RECOVER  = 3;
  localparam int TIMEOUT  = 1024;
`ifdef USB_CMD_CHECKSUM_EN
  localparam int NB = 5;
`else
  localparam int NB = 4;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  usb_d = 8'h00;
  logic        flaga = 1'b0;
  logic [1:0]  fifoadr;
  logic        sloe, slrd, valid, err;
  logic        ready = 1'b0;
  logic [7:0]  op;
  logic [23:0] arg;

  always #5 clk = ~clk;

  usb_cmd_reader #(.RD_PULSE(RD_PULSE), .RECOVER(RECOVER), .TIMEOUT(TIMEOUT)) dut (
    .mclk_i(clk), .reset_i(rst), .usb_d_i(usb_d), .usb_flaga_i(flaga),
    .usb_fifoadr_o(fifoadr), .usb_sloe_o(sloe), .usb_slrd_o(slrd),
    .cmd_valid_o(valid), .cmd_ready_i(ready), .cmd_op_o(op), .cmd_arg_o(arg),
    .cmd_err_o(err)
  );

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // FX2 FIFO contents and the frame-level expectations
  logic [7:0]  fifo[$];
  logic [31:0] exp_q[$];
  int exp_err = 0, err_seen = 0, frames_seen = 0, frames_exp = 0;
  bit hold_off = 0, tog_mode = 0, tog = 0, hs_pend = 0, held = 0;
  int rdy_mode = 1;
  int cyc = 0, last_rise = 0, last_err = 0, run = 0;
  int starts[$];
  logic [3:0]  fh = '0;
  logic        prev_slrd = 1'b1, prev_sloe = 1'b1;
  logic [7:0]  hop;
  logic [23:0] harg;

  function automatic logic [7:0] xor4(input logic [31:0] d);
    return d[31:24] ^ d[23:16] ^ d[15:8] ^ d[7:0];
  endfunction

  always @(posedge clk) fh <= {fh[2:0], flaga};

  always @(negedge clk) begin
    cyc++;
    if (slrd === 1'b0) begin
      if (prev_slrd === 1'b1 && !rst) begin
        chk("sloe_lead", prev_sloe, 0);
        chk("sync_lat", fh[3], 1);
        chk("backpressure", valid, 0);
        starts.push_back(cyc);
      end
      run++;
    end else if (prev_slrd === 1'b0) begin
      if (!rst) begin
        chk("slrd_width", run, RD_PULSE);
        chk("fifo_nonempty_on_read", fifo.size() != 0, 1);
        last_rise = cyc;
      end
      if (fifo.size() != 0) void'(fifo.pop_front());
      run = 0;
    end
    prev_slrd = slrd;
    prev_sloe = sloe;

    if (err === 1'b1) begin
      err_seen++;
      last_err = cyc;
    end

    if (hs_pend) begin
      chk("valid_drop", valid, 0);
      hs_pend = 0;
    end

    case (rdy_mode)
      0:       ready = 1'b0;
      1:       ready = 1'b1;
      default: ready = 1'($urandom_range(0, 1));
    endcase

    if (valid === 1'b1) begin
      if (held) begin
        chk("op_stable", op, hop);
        chk("arg_stable", arg, harg);
      end
      held = 1; hop = op; harg = arg;
      if (ready) begin
        frames_seen++;
        chk("frame_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          chk("op", op, exp_q[0][31:24]);
          chk("arg", arg, exp_q[0][23:0]);
          void'(exp_q.pop_front());
        end
        hs_pend = 1;
        held = 0;
      end
    end else begin
      held = 0;
    end

    tog = ~tog;
    flaga = (fifo.size() != 0) && !hold_off && (!tog_mode || tog);
    usb_d = (fifo.size() != 0) ? fifo[0] : 8'h00;
  end

  // Frame-level reference: a frame is delivered iff its check byte matches (or there is none).
  task automatic expect_frame(input logic [31:0] d, input logic [7:0] ck);
    if (NB == 4 || ck == xor4(d)) begin
      exp_q.push_back(d);
      frames_exp++;
    end else begin
      exp_err++;
    end
  endtask

  task automatic push_frame(input logic [31:0] d, input logic [7:0] ck);
    expect_frame(d, ck);
    for (int i = 3; i >= 0; i--) fifo.push_back(d[i*8 +: 8]);
    if (NB == 5) fifo.push_back(ck);
  endtask

  task automatic wait_idle(input string tag, input int max);
    int n;
    n = 0;
    while ((fifo.size() != 0 || exp_q.size() != 0 || valid !== 1'b0) && n < max) begin
      @(negedge clk);
      n++;
    end
    chk(tag, n < max, 1);
    repeat (RECOVER + 6) @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1);
  end

  initial begin
    int n, s0, e0, f0;
    logic [31:0] d;
    logic [7:0]  ck, b;

    rst = 1'b1;
    repeat (4) @(negedge clk);
    chk("rst_sloe", sloe, 1);
    chk("rst_slrd", slrd, 1);
    chk("rst_valid", valid, 0);
    chk("rst_err", err, 0);
    chk("rst_op", op, 0);
    chk("rst_arg", arg, 0);
    chk("fifoadr", fifoadr, 0);
    rst = 1'b0;

    // Streaming frame: exact spacing between strobes
    rdy_mode = 1;
    starts.delete();
    push_frame(32'h12345678, xor4(32'h12345678));
    wait_idle("t1_done", 300);
    chk("t1_nstrobe", starts.size(), NB);
    for (int i = 1; i < starts.size(); i++)
      chk("t1_spacing", starts[i] - starts[i-1], 1 + RD_PULSE + RECOVER);

    // Backpressure: no reads while a frame is held
    rdy_mode = 0;
    push_frame(32'hA1B2C3D4, xor4(32'hA1B2C3D4));
    push_frame(32'h0BADF00D, xor4(32'h0BADF00D));
    n = 0;
    while (valid !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    chk("t2_valid_up", valid, 1);
    s0 = starts.size();
    repeat (50) @(negedge clk);
    chk("t2_no_read", starts.size(), s0);
    chk("t2_valid_held", valid, 1);
    rdy_mode = 1;
    wait_idle("t2_done", 400);

    // Inter-byte timeout drops a partial frame
    e0 = err_seen;
    fifo.push_back(8'h11);
    fifo.push_back(8'h22);
    repeat (1100) @(negedge clk);
    chk("t3_err_count", err_seen - e0, 1);
    chk("t3_err_time", last_err - last_rise, RECOVER + TIMEOUT);
    exp_err++;
    push_frame(32'hAA000001, xor4(32'hAA000001));
    wait_idle("t3_done", 300);

`ifdef USB_CMD_CHECKSUM_EN
    e0 = err_seen;
    f0 = frames_seen;
    push_frame(32'h01020304, 8'h04);
    push_frame(32'h01020304, 8'h05);
    wait_idle("t4_done", 300);
    chk("t4_err", err_seen - e0, 1);
    chk("t4_frames", frames_seen - f0, 1);
`endif

    // Reset during the second strobe cycle
    push_frame(32'hDEADBEEF, xor4(32'hDEADBEEF));
    n = 0;
    while (slrd !== 1'b0 && n < 100) begin @(negedge clk); n++; end
    chk("t5_strobe_seen", slrd, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("t5_slrd", slrd, 1);
    chk("t5_sloe", sloe, 1);
    chk("t5_valid", valid, 0);
    chk("t5_err", err, 0);
    chk("t5_op", op, 0);
    chk("t5_arg", arg, 0);
    @(negedge clk);
    fifo.delete();
    exp_q.delete();
    frames_exp--;
    @(negedge clk);
    rst = 1'b0;
    push_frame(32'h13579BDF, xor4(32'h13579BDF));
    wait_idle("t5_done", 300);

    // Flag toggling every cycle, random ready
    tog_mode = 1;
    rdy_mode = 2;
    for (int i = 0; i < 3; i++) begin
      d = $urandom;
      push_frame(d, xor4(d));
    end
    wait_idle("t6_done", 2000);
    tog_mode = 0;

    // Random frames with mid-frame gaps and (when enabled) corrupt check bytes
    for (int f = 0; f < 25; f++) begin
      d = $urandom;
      ck = xor4(d);
      if (NB == 5 && $urandom_range(0, 3) == 0) ck = ck ^ 8'($urandom_range(1, 255));
      expect_frame(d, ck);
      for (int i = 0; i < NB; i++) begin
        b = (i < 4) ? d[(3-i)*8 +: 8] : ck;
        fifo.push_back(b);
        if ($urandom_range(0, 2) == 0) begin
          n = 0;
          while (fifo.size() != 0 && n < 200) begin @(negedge clk); n++; end
          repeat ($urandom_range(1, 60)) @(negedge clk);
        end
      end
    end
    wait_idle("t7_done", 5000);

    chk("err_total", err_seen, exp_err);
    chk("frame_total", frames_seen, frames_exp);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
